// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control unit: opcodes, ALU {m,s} codes,
// FSM states and register-file write-source encodings.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JC   = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU control packed as {m, s[3:0]}
  localparam logic [4:0] ALU_IDLE   = 5'b0_0000;
  localparam logic [4:0] ALU_PASS_A = 5'b0_1100;
  localparam logic [4:0] ALU_PASS_B = 5'b1_1010;
  localparam logic [4:0] ALU_NOT_B  = 5'b1_0101;
  localparam logic [4:0] ALU_AND    = 5'b1_1011;
  localparam logic [4:0] ALU_SUB    = 5'b1_0110;
  localparam logic [4:0] ALU_ADD    = 5'b1_1001;

  localparam logic [1:0] WSRC_ALU = 2'd0;
  localparam logic [1:0] WSRC_IMM = 2'd1;
  localparam logic [1:0] WSRC_MEM = 2'd2;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StImm,
    StExec,
    StMem,
    StHalt
  } state_e;

  function automatic logic is_mem_op(logic [3:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

endpackage

// File: rtl/cpu_ctrl_if.sv
// Memory bus between the control unit (master) and instruction/data memory (slave).
interface cpu_ctrl_if;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/alu_op_decode.sv
// Opcode classifier: ALU {m,s} code plus writeback/flag/length attributes.
// Purely combinational so trace tooling can share it.
module alu_op_decode
  import cpu_pkg::*;
(
  input  logic [3:0] op_i,
  output logic       alu_m_o,
  output logic [3:0] alu_s_o,
  output logic       writes_rd_o,
  output logic       sets_flags_o,
  output logic       two_byte_o
);

  logic [4:0] code;

  always_comb begin
    code         = ALU_IDLE;
    writes_rd_o  = 1'b0;
    sets_flags_o = 1'b0;
    two_byte_o   = 1'b0;
    unique case (op_i)
      OP_MOV: begin
        code        = ALU_PASS_A;
        writes_rd_o = 1'b1;
      end
      OP_ADD: begin
        code         = ALU_ADD;
        writes_rd_o  = 1'b1;
        sets_flags_o = 1'b1;
      end
      OP_SUB: begin
        code         = ALU_SUB;
        writes_rd_o  = 1'b1;
        sets_flags_o = 1'b1;
      end
      OP_AND: begin
        code        = ALU_AND;
        writes_rd_o = 1'b1;
      end
      OP_NOT: begin
        code        = ALU_NOT_B;
        writes_rd_o = 1'b1;
      end
      OP_LDI, OP_LD: begin
        writes_rd_o = 1'b1;
        two_byte_o  = 1'b1;
      end
      OP_ST, OP_JMP, OP_JC, OP_JZ: two_byte_o = 1'b1;
      default: ;
    endcase
  end

  assign {alu_m_o, alu_s_o} = code;

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/execute control unit for the 8-bit CPU. Drives the
// memory bus, ALU mode/select and register-file write controls; holds C/Z flags.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  cpu_ctrl_if.master       mem,
  output logic             alu_m,
  output logic [3:0]       alu_s,
  input  logic             alu_cf,
  input  logic             alu_zf,
  output logic [1:0]       rs_sel,
  output logic [1:0]       rd_sel,
  output logic             reg_we,
  output logic [1:0]       reg_wsrc,
  output logic [7:0]       imm,
  output logic [7:0]       pc,
  output logic             flag_c,
  output logic             flag_z,
  output logic             halted
);

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] imm_q, imm_d;
  logic       flag_c_q, flag_c_d;
  logic       flag_z_q, flag_z_d;

  logic [3:0] op;
  logic       dec_m;
  logic [3:0] dec_s;
  logic       dec_writes_rd;
  logic       dec_sets_flags;
  logic       dec_two_byte;
  logic       dec_is_alu;
  logic       jump_taken;

  logic       req_c, we_c, reg_we_c;
  logic [7:0] addr_c;

  assign op = ir_q[7:4];

  alu_op_decode u_alu_op_decode (
    .op_i         (op),
    .alu_m_o      (dec_m),
    .alu_s_o      (dec_s),
    .writes_rd_o  (dec_writes_rd),
    .sets_flags_o (dec_sets_flags),
    .two_byte_o   (dec_two_byte)
  );

  assign dec_is_alu = ({dec_m, dec_s} != ALU_IDLE);
  assign jump_taken = (op == OP_JMP) || ((op == OP_JC) && flag_c_q) ||
                      ((op == OP_JZ) && flag_z_q);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    imm_d    = imm_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    req_c    = 1'b0;
    we_c     = 1'b0;
    addr_c   = pc_q;
    alu_m    = 1'b0;
    alu_s    = 4'b0000;
    reg_we_c = 1'b0;
    reg_wsrc = WSRC_ALU;
    halted   = 1'b0;
    unique case (state_q)
      StFetch: begin
        req_c = 1'b1;
        if (mem.mem_ready) begin
          ir_d    = mem.mem_rdata;
          pc_d    = pc_q + 8'd1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (dec_two_byte)        state_d = StImm;
        else if (op == OP_HALT)  state_d = StHalt;
        else                     state_d = StExec;
      end
      StImm: begin
        req_c = 1'b1;
        if (mem.mem_ready) begin
          imm_d   = mem.mem_rdata;
          pc_d    = pc_q + 8'd1;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = is_mem_op(op) ? StMem : StFetch;
        if (dec_is_alu) begin
          alu_m = dec_m;
          alu_s = dec_s;
        end
        // LD writes back from the MEM state instead
        if (dec_writes_rd && (op != OP_LD)) begin
          reg_we_c = 1'b1;
          reg_wsrc = dec_is_alu ? WSRC_ALU : WSRC_IMM;
        end
        if (dec_sets_flags) begin
          flag_c_d = alu_cf;
          flag_z_d = alu_zf;
        end
        if (jump_taken) pc_d = imm_q;
      end
      StMem: begin
        req_c  = 1'b1;
        addr_c = imm_q;
        we_c   = (op == OP_ST);
        if (mem.mem_ready) begin
          if (dec_writes_rd) begin
            reg_we_c = 1'b1;
            reg_wsrc = WSRC_MEM;
          end
          state_d = StFetch;
        end
      end
      StHalt: halted = 1'b1;
      default: state_d = StFetch;
    endcase
    // Strobes are quiet while reset is held even though state already reads FETCH.
    if (rst) begin
      req_c    = 1'b0;
      we_c     = 1'b0;
      reg_we_c = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      ir_q     <= 8'h00;
      imm_q    <= 8'h00;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      imm_q    <= imm_d;
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign mem.mem_req  = req_c;
  assign mem.mem_we   = we_c;
  assign mem.mem_addr = addr_c;
  assign reg_we       = reg_we_c;
  assign rs_sel       = ir_q[3:2];
  assign rd_sel       = ir_q[1:0];
  assign imm          = imm_q;
  assign pc           = pc_q;
  assign flag_c       = flag_c_q;
  assign flag_z       = flag_z_q;

endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
Multi-cycle control unit for the simple 8-bit CPU. It fetches and decodes instructions and drives the ALU's mode/select inputs (m, s). It consumes the ALU's cf/zf results to hold the flag registers and resolve conditional jumps. It sits between instruction/data memory and the datapath (register file plus ALU); the datapath routes a = R[rs] and b = R[rd].

Parameters:
RESET_PC, 8'h00, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
mem_req  out  1  memory transfer request
mem_we  out  1  1=write (ST), 0=read
mem_addr  out  8  address; PC during fetch, imm during LD/ST
mem_rdata  in  8  read data; valid when mem_ready=1
mem_ready  in  1  transfer completes on the cycle mem_req&&mem_ready
alu_m  out  1  ALU mode
alu_s  out  4  ALU select
alu_cf  in  1  ALU carry
alu_zf  in  1  ALU zero
rs_sel  out  2  source register (drives ALU a, ST write data)
rd_sel  out  2  destination register (drives ALU b)
reg_we  out  1  register-file write strobe
reg_wsrc  out  2  write source: 0=ALU t, 1=imm, 2=mem_rdata
imm  out  8  latched immediate byte
pc  out  8  program counter
flag_c, flag_z  out  1 each  registered flags
halted  out  1  high in HALT state

Behaviour:
- Instruction byte: op[7:4], rs[3:2], rd[1:0]. Two-byte ops (LDI, LD, ST, JMP, JC, JZ) are followed by an imm byte at pc+1.
- Ops and ALU codes:
  - 0 NOP.
  - 1 MOV rd<-rs: m=0, s=1100.
  - 2 ADD rd<-rd+rs: m=1, s=1001.
  - 3 SUB rd<-rd-rs: m=1, s=0110.
  - 4 AND: m=1, s=1011.
  - 5 NOT rd<-~rd: m=1, s=0101.
  - 6 LDI rd<-imm.
  - 7 LD rd<-[imm].
  - 8 ST [imm]<-rs.
  - 9 JMP imm.
  - A JC: jump if flag_c.
  - B JZ: jump if flag_z.
  - F HALT.
  - C, D, E: execute as NOP.
- Outside EXEC of an ALU op: alu_m=0, alu_s=0000 (ALU idle, t=0). reg_we=0.
- States:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ready, latch IR and pc<=pc+1.
  - DECODE: one cycle. Two-byte ops go to IMM, HALT goes to HALT, all others go to EXEC.
  - IMM: read at pc. On ready, latch imm and pc<=pc+1, then go to EXEC.
  - EXEC:
    - ALU ops: drive m/s and reg_we=1 with wsrc=0.
    - LDI: reg_we=1 with wsrc=1.
    - Jumps: pc<=imm if taken.
    - LD/ST go to MEM; everything else goes to FETCH.
  - MEM: mem_req=1, mem_addr=imm, mem_we=(op==ST).
    - LD: on ready, reg_we=1 with wsrc=2 in the same cycle.
    - Then go to FETCH.
  - HALT: all strobes 0, halted=1. Exit only by rst.
- Zero-wait latency: ALU op/NOP 3 cycles; LDI/jumps 4; LD/ST 5. Each wait cycle (mem_ready=0) adds 1; mem_addr and mem_we are held stable while waiting.
- Flags: flag_c<=alu_cf and flag_z<=alu_zf at the end of EXEC for ADD/SUB only. All other ops leave both flags unchanged.
- SUB borrow: b<a sets flag_c=1. Example: 3-5 gives t=FE, c=1.
- A JC/JZ immediately after the ADD/SUB that set the flag sees the new value.
- PC wraps FF->00 on increment, including during the imm fetch.
- Reset (async, any state, including mid-handshake):
  - state=FETCH, pc=RESET_PC, IR=00, imm=00, flags=0.
  - mem_req=0, reg_we=0, halted=0, alu_m=0, alu_s=0000.
  - Fetch begins on the first clock edge after rst deasserts; mem_req is combinational from state, so it rises in that cycle.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants;
  - ALU {m,s} code constants (PASS_A, PASS_B, NOT_B, AND, SUB, ADD, IDLE);
  - state enum;
  - reg_wsrc encodings.
- One natural sub-module: alu_op_decode. Combinational: op -> {alu_m, alu_s, writes_rd, sets_flags, two_byte}. It is reused by the disassembler/trace monitor.

Test Plan:
- Reset release, mem: 00:61 05, 02:62 03, 04:36 (LDI R1,5; LDI R2,3; SUB R2-R1), zero-wait -> EXEC of SUB drives m=1 s=0110, rd=2, rs=1; flag_c=1, flag_z=0; pc=05 after.
- ADD rd+rs with datapath returning cf=1, zf=1 (FF+01) -> flag_c=1, flag_z=1; a following JZ 40 loads pc=40; a following MOV leaves flags unchanged.
- mem_ready held low 3 cycles during FETCH -> mem_req/mem_addr stable for 4 cycles, IR latched only on the ready cycle, total instruction 6 cycles.
- ST at pc=FE with imm at FF -> pc wraps to 00. MEM cycle asserts mem_we=1, mem_addr=imm, rs_sel correct.
- Assert rst during MEM of an LD with mem_ready=0 -> mem_req drops immediately, pc=RESET_PC, no reg_we pulse, fetch restarts.
- Opcode F0 -> halted=1 after DECODE, no further mem_req for 20 cycles. Opcode D0 -> behaves as NOP (3 cycles, no writes).
